// File: rtl/mux_key_sync.sv
// Key-lookup multiplexer: selects the data word of the first (key,data) pair
// whose key equals the lookup key, with a combinational result and a registered copy.
module mux_key_sync #(
  parameter int unsigned          NR_KEY      = 2,
  parameter int unsigned          KEY_LEN     = 1,
  parameter int unsigned          DATA_LEN    = 1,
  parameter logic [DATA_LEN-1:0]  DEFAULT_OUT = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  input  logic                                 en_i,
  output logic [DATA_LEN-1:0]                  out,
  output logic                                 hit,
  output logic [DATA_LEN-1:0]                  out_q,
  output logic                                 hit_q
);

  localparam int unsigned PAIR = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  w_key  [NR_KEY];
  logic [DATA_LEN-1:0] w_data [NR_KEY];
  logic [NR_KEY-1:0]   w_match;
  logic [DATA_LEN-1:0] w_out;
  logic                w_hit;
  logic [DATA_LEN-1:0] r_out_q;
  logic                r_hit_q;

  // Entry 0 sits in the most-significant pair so callers can write {k0,d0,k1,d1,...}.
  for (genvar gj = 0; gj < NR_KEY; gj++) begin : g_entry
    assign w_key[gj]   = lut[(NR_KEY-gj)*PAIR-1 -: KEY_LEN];
    assign w_data[gj]  = lut[(NR_KEY-gj)*PAIR-KEY_LEN-1 -: DATA_LEN];
    assign w_match[gj] = (w_key[gj] == key);
  end

  // Priority select: the first matching entry wins; no match yields the default word.
  always_comb begin
    w_out = DEFAULT_OUT;
    w_hit = 1'b0;
    for (int j = 0; j < int'(NR_KEY); j++) begin
      if (w_match[j] && !w_hit) begin
        w_out = w_data[j];
        w_hit = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
  end

  assign out = w_out;
  assign hit = w_hit;

  // Pipelined copy of the lookup; reset takes priority over the capture enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_q <= DEFAULT_OUT;
      r_hit_q <= 1'b0;
    end else if (en_i) begin
      r_out_q <= w_out;
      r_hit_q <= w_hit;
    end else begin
      r_out_q <= r_out_q;
      r_hit_q <= r_hit_q;
    end
  end

  assign out_q = r_out_q;
  assign hit_q = r_hit_q;

endmodule

// File: tb/tb_mux_key_sync.sv
// Self-checking bench for mux_key_sync: fixed vector table, registered-path
// sequences and randomised lookups against a first-match reference model.
module tb_mux_key_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;
  int   n_cmp = 0;
  int   n_err = 0;

  // 4-entry byte-lane table
  logic [1:0]  k4;
  logic [39:0] lut4;
  logic [7:0]  o4, o4q;
  logic        h4, h4q;
  // 6-entry table, keys 0..5
  logic [2:0]  k6;
  logic [65:0] lut6;
  logic [7:0]  o6, o6q;
  logic        h6, h6q;
  // duplicate-key table
  logic        kd;
  logic [17:0] lutd;
  logic [7:0]  od, odq;
  logic        hd, hdq;
  // wide randomised table with a non-zero default
  localparam logic [31:0] RDEF = 32'hDEAD_BEEF;
  logic [3:0]   kr;
  logic [575:0] lutr;
  logic [31:0]  orr, orq;
  logic         hr, hrq;

  mux_key_sync #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u4 (
    .clk_i(clk), .rst_i(rst), .key(k4), .lut(lut4), .en_i(en),
    .out(o4), .hit(h4), .out_q(o4q), .hit_q(h4q));
  mux_key_sync #(.NR_KEY(6), .KEY_LEN(3), .DATA_LEN(8)) u6 (
    .clk_i(clk), .rst_i(rst), .key(k6), .lut(lut6), .en_i(en),
    .out(o6), .hit(h6), .out_q(o6q), .hit_q(h6q));
  mux_key_sync #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(8)) ud (
    .clk_i(clk), .rst_i(rst), .key(kd), .lut(lutd), .en_i(en),
    .out(od), .hit(hd), .out_q(odq), .hit_q(hdq));
  mux_key_sync #(.NR_KEY(16), .KEY_LEN(4), .DATA_LEN(32), .DEFAULT_OUT(RDEF)) ur (
    .clk_i(clk), .rst_i(rst), .key(kr), .lut(lutr), .en_i(en),
    .out(orr), .hit(hr), .out_q(orq), .hit_q(hrq));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          sel;      // 0: 4-entry, 1: 6-entry, 2: duplicate table
    logic [3:0]  key;
    logic [7:0]  exp_out;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[$];

  // random-table model state
  logic [3:0]  mk [16];
  logic [31:0] md [16];
  logic [3:0]  probe;
  logic [31:0] eo, eq_o;
  logic        eh, eq_h;

  initial begin
    rst = 1'b1; en = 1'b1;
    k4 = 2'b00; k6 = 3'b000; kd = 1'b0; kr = 4'h0;
    lut4 = {2'b11, 8'hAA, 2'b10, 8'hBB, 2'b01, 8'hCC, 2'b00, 8'hDD};
    lut6 = '0;
    for (int j = 0; j < 6; j++) lut6 = (lut6 << 11) | 66'({3'(j), 8'(8'h10 + j)});
    lutd = {1'b0, 8'h11, 1'b0, 8'h22};
    lutr = '0;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out_q4", 32'(o4q), 32'h00);
    chk("rst_hit_q4", 32'(h4q), 32'h0);
    chk("rst_out_qr", orq, RDEF);
    chk("rst_hit_qr", 32'(hrq), 32'h0);

    // combinational vector table
    vecs.push_back('{0, 4'd0, 8'hDD, 1'b1});
    vecs.push_back('{0, 4'd1, 8'hCC, 1'b1});
    vecs.push_back('{0, 4'd2, 8'hBB, 1'b1});
    vecs.push_back('{0, 4'd3, 8'hAA, 1'b1});
    for (int k = 0; k < 6; k++) vecs.push_back('{1, 4'(k), 8'(8'h10 + k), 1'b1});
    vecs.push_back('{1, 4'd6, 8'h00, 1'b0});
    vecs.push_back('{1, 4'd7, 8'h00, 1'b0});
    vecs.push_back('{2, 4'd0, 8'h11, 1'b1});
    vecs.push_back('{2, 4'd1, 8'h00, 1'b0});
    foreach (vecs[i]) begin
      k4 = vecs[i].key[1:0]; k6 = vecs[i].key[2:0]; kd = vecs[i].key[0];
      #1;
      case (vecs[i].sel)
        0: begin chk($sformatf("out4_k%0d", vecs[i].key), 32'(o4), 32'(vecs[i].exp_out));
                 chk($sformatf("hit4_k%0d", vecs[i].key), 32'(h4), 32'(vecs[i].exp_hit)); end
        1: begin chk($sformatf("out6_k%0d", vecs[i].key), 32'(o6), 32'(vecs[i].exp_out));
                 chk($sformatf("hit6_k%0d", vecs[i].key), 32'(h6), 32'(vecs[i].exp_hit)); end
        default: begin chk($sformatf("outd_k%0d", vecs[i].key), 32'(od), 32'(vecs[i].exp_out));
                 chk($sformatf("hitd_k%0d", vecs[i].key), 32'(hd), 32'(vecs[i].exp_hit)); end
      endcase
    end

    // registered path: capture, hold, reset, resume
    @(negedge clk); rst = 1'b0; en = 1'b1; k4 = 2'b01;
    @(posedge clk); #1;
    chk("cap_out_q", 32'(o4q), 32'hCC);
    chk("cap_hit_q", 32'(h4q), 32'h1);
    @(negedge clk); en = 1'b0; k4 = 2'b10;
    @(posedge clk); #1;
    chk("hold_out_q", 32'(o4q), 32'hCC);
    chk("hold_out",   32'(o4),  32'hBB);
    @(negedge clk); en = 1'b1; rst = 1'b1; k4 = 2'b11;
    @(posedge clk); #1;
    chk("mrst_out_q", 32'(o4q), 32'h00);
    chk("mrst_hit_q", 32'(h4q), 32'h0);
    chk("mrst_out",   32'(o4),  32'hAA);
    chk("mrst_hit",   32'(h4),  32'h1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("resume_out_q", 32'(o4q), 32'hAA);
    chk("resume_hit_q", 32'(h4q), 32'h1);

    // randomised lookups with a first-match model and a register model
    eq_o = orq; eq_h = hrq;
    for (int it = 0; it < 300; it++) begin
      int mode;
      @(negedge clk);
      mode = int'($urandom_range(0, 2));
      for (int j = 0; j < 16; j++) begin
        md[j] = $urandom;
        mk[j] = (mode == 1) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
      end
      probe = (mode == 1) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 15));
      if (mode == 2) begin
        mk[$urandom_range(8, 15)] = probe;
        mk[$urandom_range(0, 7)]  = probe;
      end
      lutr = '0;
      for (int j = 0; j < 16; j++) lutr = (lutr << 36) | 576'({mk[j], md[j]});
      kr  = probe;
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 15) == 0);
      eo = RDEF; eh = 1'b0;
      for (int j = 15; j >= 0; j--) if (mk[j] == probe) begin eo = md[j]; eh = 1'b1; end
      #1;
      chk($sformatf("rnd_out_%0d", it), orr, eo);
      chk($sformatf("rnd_hit_%0d", it), 32'(hr), 32'(eh));
      if (rst) begin eq_o = RDEF; eq_h = 1'b0; end
      else if (en) begin eq_o = eo; eq_h = eh; end
      @(posedge clk); #1;
      chk($sformatf("rnd_out_q_%0d", it), orq, eq_o);
      chk($sformatf("rnd_hit_q_%0d", it), 32'(hrq), 32'(eq_h));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
